// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pkg
// Description : Immediate-extension mode codes and the shared extend function.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_ext_pkg;

    // Widest result the shared extend function can produce.
    localparam int c_EXT_MAX_W = 64;

    typedef enum logic [1:0] {
        IMM_SIGN   = 2'b00,
        IMM_ZERO   = 2'b01,
        IMM_UPPER  = 2'b10,
        IMM_BRANCH = 2'b11
    } imm_mode_e;

    function automatic logic [c_EXT_MAX_W-1:0] low_mask(input int w);
        if (w >= c_EXT_MAX_W) begin
            return '1;
        end
        return (64'd1 << w) - 64'd1;
    endfunction

    // Widths are passed as arguments so one function serves every
    // parameterisation; callers truncate the result to their OUT_W.
    function automatic logic [c_EXT_MAX_W-1:0] extend_imm(
        input logic [c_EXT_MAX_W-1:0] imm,
        input logic [1:0]             mode,
        input int                     in_w,
        input int                     out_w,
        input int                     br_shift
    );
        logic [c_EXT_MAX_W-1:0] raw;
        logic [c_EXT_MAX_W-1:0] sext;
        logic [c_EXT_MAX_W-1:0] res;
        raw  = imm & low_mask(in_w);
        sext = raw;
        if ((raw & (64'd1 << (in_w - 1))) != '0) begin
            sext = raw | ~low_mask(in_w);
        end
        case (mode)
            IMM_SIGN:   res = sext;
            IMM_ZERO:   res = raw;
            IMM_UPPER:  res = raw << (out_w - in_w);
            IMM_BRANCH: res = sext << br_shift;
            default:    res = '0;
        endcase
        return res & low_mask(out_w);
    endfunction

endpackage : imm_ext_pkg
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_buf
// Description : Two-entry valid/ready register slice (output reg + skid reg).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buf #(
    parameter int DATA_W = 37
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    generate
        if (DATA_W < 1) begin : g_param_check_fail
            $error("pipe_skid_buf: DATA_W must be at least 1");
        end
    endgenerate

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              w_in_xfer;
    logic              w_out_load;

    // in_ready comes only from a flop, so out_ready never reaches upstream.
    assign in_ready   = ~r_skid_valid;
    assign w_in_xfer  = in_valid & ~r_skid_valid;
    assign w_out_load = ~r_out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (w_out_load) begin
            if (r_skid_valid) begin
                // Skid is older than any input, so it drains first.
                r_out_valid  <= 1'b1;
                r_out_data   <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_xfer) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule : pipe_skid_buf
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_pipe
// Description : Registered immediate extender (sign/zero/upper/branch) with skid.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag
);

    localparam int c_DATA_W = OUT_W + TAG_W;

    generate
        if (IN_W < 1 || OUT_W < IN_W + BR_SHIFT || OUT_W > c_EXT_MAX_W)
        begin : g_param_check_fail
            $error("imm_extend_pipe: illegal IN_W/OUT_W/BR_SHIFT combination");
        end
    endgenerate

    logic [OUT_W-1:0]    w_ext_imm;
    logic [c_DATA_W-1:0] w_in_data;
    logic [c_DATA_W-1:0] w_out_data;

    assign w_ext_imm = OUT_W'(extend_imm(c_EXT_MAX_W'(in_imm), in_mode,
                                         IN_W, OUT_W, BR_SHIFT));
    assign w_in_data = {in_tag, w_ext_imm};

    pipe_skid_buf #(
        .DATA_W (c_DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_data)
    );

    assign out_imm = w_out_data[OUT_W-1:0];
    assign out_tag = w_out_data[c_DATA_W-1:OUT_W];

endmodule : imm_extend_pipe
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend_pipe
// Description : Directed and random self-checking bench for imm_extend_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;
    import imm_ext_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [4:0]  out_tag;

    int n_checks = 0;
    int n_fail   = 0;

    imm_extend_pipe #(
        .IN_W     (16),
        .OUT_W    (32),
        .BR_SHIFT (2),
        .TAG_W    (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] imm,
                         input logic [4:0] tag);
        in_valid = v;
        in_mode  = m;
        in_imm   = imm;
        in_tag   = tag;
    endtask

    // Checks out_valid, out_imm, out_tag and in_ready in one go.
    task automatic check_out(input string tag, input logic v, input logic [31:0] imm,
                             input logic [4:0] t, input logic rdy);
        check({tag, "_valid"}, 64'(out_valid), 64'(v));
        check({tag, "_imm"},   64'(out_imm),   64'(imm));
        check({tag, "_tag"},   64'(out_tag),   64'(t));
        check({tag, "_ready"}, 64'(in_ready),  64'(rdy));
    endtask

    logic [1:0]  sw_mode [5];
    logic [15:0] sw_imm  [5];
    logic [31:0] sw_exp  [5];

    logic [36:0] sb_q [$];
    logic [36:0] sb_e;
    logic [31:0] r_exp;
    int          accepted;
    int          received;
    logic        last_xfer;
    logic        prev_stall;
    logic [31:0] prev_imm;
    logic [4:0]  prev_tag;

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 2'b00, 16'h0, 5'h0);
        repeat (2) @(negedge clk);
        check_out("reset", 1'b0, 32'h0, 5'h0, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Mode sweep
        sw_mode[0] = IMM_SIGN;   sw_imm[0] = 16'h8001; sw_exp[0] = 32'hFFFF8001;
        sw_mode[1] = IMM_ZERO;   sw_imm[1] = 16'h8001; sw_exp[1] = 32'h00008001;
        sw_mode[2] = IMM_UPPER;  sw_imm[2] = 16'h1234; sw_exp[2] = 32'h12340000;
        sw_mode[3] = IMM_BRANCH; sw_imm[3] = 16'hFFFF; sw_exp[3] = 32'hFFFFFFFC;
        sw_mode[4] = IMM_BRANCH; sw_imm[4] = 16'h0001; sw_exp[4] = 32'h00000004;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, sw_mode[i], sw_imm[i], 5'(i + 1));
            @(negedge clk);
            check_out($sformatf("sweep%0d", i), 1'b1, sw_exp[i], 5'(i + 1), 1'b1);
        end
        drive(1'b0, 2'b00, 16'h0, 5'h0);
        @(negedge clk);
        check("sweep_idle_valid", 64'(out_valid), 64'd0);

        // Streaming: 16 back-to-back zero-extended beats
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, IMM_ZERO, 16'(i * 16'h1111), 5'(i));
            @(negedge clk);
            check_out($sformatf("stream%0d", i), 1'b1, 32'(i * 32'h1111), 5'(i), 1'b1);
        end
        drive(1'b0, 2'b00, 16'h0, 5'h0);
        @(negedge clk);
        check("stream_idle_valid", 64'(out_valid), 64'd0);

        // Back-pressure: A in output reg, B in skid, C held off
        out_ready = 1'b0;
        drive(1'b1, IMM_SIGN, 16'h00A0, 5'd10);
        @(negedge clk);
        check_out("bp_a", 1'b1, 32'h000000A0, 5'd10, 1'b1);
        drive(1'b1, IMM_ZERO, 16'hB000, 5'd11);
        @(negedge clk);
        check_out("bp_b_in", 1'b1, 32'h000000A0, 5'd10, 1'b0);
        drive(1'b1, IMM_UPPER, 16'h00C0, 5'd12);
        @(negedge clk);
        check_out("bp_hold1", 1'b1, 32'h000000A0, 5'd10, 1'b0);
        @(negedge clk);
        check_out("bp_hold2", 1'b1, 32'h000000A0, 5'd10, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        check_out("bp_out_b", 1'b1, 32'h0000B000, 5'd11, 1'b1);
        @(negedge clk);
        check_out("bp_out_c", 1'b1, 32'h00C00000, 5'd12, 1'b1);
        drive(1'b0, 2'b00, 16'h0, 5'h0);
        @(negedge clk);
        check("bp_idle_valid", 64'(out_valid), 64'd0);

        // Simultaneous output and input transfer with the skid empty
        drive(1'b1, IMM_SIGN, 16'h0123, 5'd13);
        @(negedge clk);
        check_out("sim_d", 1'b1, 32'h00000123, 5'd13, 1'b1);
        drive(1'b1, IMM_BRANCH, 16'h0010, 5'd14);
        @(negedge clk);
        check_out("sim_e", 1'b1, 32'h00000040, 5'd14, 1'b1);
        drive(1'b0, 2'b00, 16'h0, 5'h0);
        @(negedge clk);

        // Reset with both entries full
        out_ready = 1'b0;
        drive(1'b1, IMM_ZERO, 16'h1111, 5'd1);
        @(negedge clk);
        drive(1'b1, IMM_ZERO, 16'h2222, 5'd2);
        @(negedge clk);
        check("rm_full_ready", 64'(in_ready), 64'd0);
        drive(1'b0, 2'b00, 16'h0, 5'h0);
        #2 rst_n = 1'b0;
        #1;
        check_out("rm_async", 1'b0, 32'h0, 5'h0, 1'b1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("rm_no_old_valid", 64'(out_valid), 64'd0);
        drive(1'b1, IMM_SIGN, 16'h7FFF, 5'd7);
        @(negedge clk);
        check_out("rm_first", 1'b1, 32'h00007FFF, 5'd7, 1'b1);
        drive(1'b0, 2'b00, 16'h0, 5'h0);
        @(negedge clk);
        check("rm_idle_valid", 64'(out_valid), 64'd0);

        // Random traffic against the package reference function
        accepted   = 0;
        received   = 0;
        last_xfer  = 1'b0;
        prev_stall = 1'b0;
        prev_imm   = '0;
        prev_tag   = '0;
        for (int cyc = 0; cyc < 60000 && received < 10000; cyc++) begin
            if (prev_stall) begin
                check("rnd_stall_hold", {27'd0, out_valid, out_tag, out_imm},
                      {27'd0, 1'b1, prev_tag, prev_imm});
            end
            if (!in_valid || last_xfer) begin
                if (accepted < 10000 && $urandom_range(9) < 7) begin
                    drive(1'b1, 2'($urandom_range(3)), 16'($urandom), 5'($urandom));
                end else begin
                    drive(1'b0, 2'b00, 16'h0, 5'h0);
                end
            end
            out_ready = ($urandom_range(9) < 7);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("rnd_spurious", 64'd1, 64'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("rnd_beat", {27'd0, out_tag, out_imm}, {27'd0, sb_e});
                end
                received++;
            end
            last_xfer = in_valid && in_ready;
            if (last_xfer) begin
                r_exp = 32'(extend_imm(64'(in_imm), in_mode, 16, 32, 2));
                sb_q.push_back({in_tag, r_exp});
                accepted++;
            end
            prev_stall = out_valid && !out_ready;
            prev_imm   = out_imm;
            prev_tag   = out_tag;
            @(negedge clk);
        end
        check("rnd_received", 64'(received), 64'd10000);
        check("rnd_leftover", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_imm_extend_pipe
`default_nettype wire
